// File: rtl/bfly4_out_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bfly4_out_serializer_pkg
//  Description : Shared FFT definitions: default sample width, radix-4 frame
//                length and the complex-sample record.
//  Revision    : 1.0 - initial release
// ============================================================================
package bfly4_out_serializer_pkg;

    // Width of each real / imaginary component (signed two's complement)
    localparam int WIDTH     = 32;

    // Samples per radix-4 butterfly frame
    localparam int FRAME_LEN = 4;

    // Number of frame slots in the ping-pong buffer
    localparam int NUM_SLOTS = 2;

    // One complex sample
    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_t;

endpackage
`default_nettype wire

// File: rtl/bfly4_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bfly4_out_serializer
//  Description : Captures complete radix-4 butterfly frames (four complex
//                samples delivered in parallel) into a two-slot ping-pong
//                buffer and streams them out one sample per cycle, in order
//                in0..in3, over a valid/ready handshake. Frames offered while
//                both slots are occupied are dropped and latch a sticky
//                overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bfly4_out_serializer #(
    parameter int WIDTH = bfly4_out_serializer_pkg::WIDTH
) (
    input  logic                    clock,
    input  logic                    resetn,

    // Butterfly side: one whole frame per handshake
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in0r,
    input  logic signed [WIDTH-1:0] in0i,
    input  logic signed [WIDTH-1:0] in1r,
    input  logic signed [WIDTH-1:0] in1i,
    input  logic signed [WIDTH-1:0] in2r,
    input  logic signed [WIDTH-1:0] in2i,
    input  logic signed [WIDTH-1:0] in3r,
    input  logic signed [WIDTH-1:0] in3i,
    output logic                    in_ready,

    // SDF side: one sample per handshake
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_r,
    output logic signed [WIDTH-1:0] out_i,
    output logic [1:0]              out_idx,
    output logic                    out_last,

    // Sticky: a frame has been dropped since reset
    output logic                    overflow
);

    import bfly4_out_serializer_pkg::*;

    localparam logic [1:0] c_last_idx = 2'(FRAME_LEN - 1);
    localparam logic [1:0] c_full_cnt = 2'(NUM_SLOTS);

    // ------------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------------
    // Frame storage is never reset: a slot is only ever read after it has
    // been written, and the output mux forces zero while nothing is valid.
    logic signed [WIDTH-1:0] r_buf_re [NUM_SLOTS][FRAME_LEN];
    logic signed [WIDTH-1:0] r_buf_im [NUM_SLOTS][FRAME_LEN];

    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic [1:0] r_idx;
    logic       r_overflow;

    logic signed [WIDTH-1:0] w_in_re [FRAME_LEN];
    logic signed [WIDTH-1:0] w_in_im [FRAME_LEN];

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_drop;
    logic w_xfer;
    logic w_xfer_last;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // in_ready looks only at the registered count so that a full buffer never
    // becomes ready through a same-cycle pop; this keeps in_ready free of any
    // combinational path from out_ready.
    assign w_in_ready  = (r_count < c_full_cnt);
    assign w_out_valid = (r_count != 2'd0);
    assign w_accept    = in_valid &  w_in_ready;
    assign w_drop      = in_valid & ~w_in_ready;
    assign w_xfer      = w_out_valid & out_ready;
    assign w_xfer_last = w_xfer & (r_idx == c_last_idx);

    // Gather the parallel butterfly outputs into sample order in0..in3
    always_comb begin
        w_in_re[0] = in0r;
        w_in_im[0] = in0i;
        w_in_re[1] = in1r;
        w_in_im[1] = in1i;
        w_in_re[2] = in2r;
        w_in_im[2] = in2i;
        w_in_re[3] = in3r;
        w_in_im[3] = in3i;
    end

    // Write an accepted frame into the slot selected by the write pointer
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                r_buf_re[r_wr_ptr][k] <= w_in_re[k];
                r_buf_im[r_wr_ptr][k] <= w_in_im[k];
            end
        end
    end

    // Pointer, occupancy, sample index and overflow bookkeeping
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_idx      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            if (w_xfer_last) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            // Accept and frame retirement in the same cycle cancel out
            case ({w_accept, w_xfer_last})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            // Index walks 0..3 and wraps back to 0 as the frame retires
            if (w_xfer) begin
                r_idx <= (r_idx == c_last_idx) ? 2'd0 : r_idx + 2'd1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Present the current sample of the oldest frame; zero when empty
    always_comb begin
        out_r = '0;
        out_i = '0;
        if (w_out_valid) begin
            out_r = r_buf_re[r_rd_ptr][r_idx];
            out_i = r_buf_im[r_rd_ptr][r_idx];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_idx   = r_idx;
    assign out_last  = (r_idx == c_last_idx);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/bfly4_out_serializer.md
BFLY4_OUT_SERIALIZER -- requirements
Module: bfly4_out_serializer

Interface
REQ-001 Parameter WIDTH SHALL be declared with default 32: the width of each real and imaginary sample component, signed two's complement.
REQ-002 Port clock SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port resetn SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-004 Port in_valid SHALL be input, 1 bit: a butterfly frame is present; driven by the butterfly_radix4 done.
REQ-005 Ports in0r, in0i, in1r, in1i, in2r, in2i, in3r, in3i SHALL be inputs, WIDTH bits each, signed: butterfly outputs out1..out4, real and imaginary.
REQ-006 Port in_ready SHALL be output, 1 bit: a buffer slot is free.
REQ-007 Port out_valid SHALL be output, 1 bit: out_r, out_i, out_idx and out_last hold a valid sample.
REQ-008 Port out_ready SHALL be input, 1 bit: the downstream SDF stage accepts the sample.
REQ-009 Ports out_r and out_i SHALL be outputs, WIDTH bits each, signed: the serialized sample.
REQ-010 Port out_idx SHALL be output, 2 bits: position of the sample within its frame, 0..3.
REQ-011 Port out_last SHALL be output, 1 bit: asserted exactly when out_idx==3.
REQ-012 Port overflow SHALL be output, 1 bit: sticky flag, set when a frame is dropped.

Function
REQ-013 The block SHALL store up to 2 complete frames (4 complex samples each) in a ping-pong buffer, using a 1-bit write pointer, a 1-bit read pointer and a 2-bit frame count (0..2).
REQ-014 in_ready SHALL equal (count<2), derived from registered state only; a same-cycle pop SHALL NOT make a full buffer ready.
REQ-015 A frame SHALL be accepted on a rising edge where in_valid && in_ready; on acceptance, all 8 components SHALL be written to slot wr_ptr, wr_ptr SHALL toggle and count SHALL increment.
REQ-016 When in_valid && !in_ready, the frame SHALL be discarded, overflow SHALL be set to 1 and SHALL remain 1 until reset; buffer contents SHALL be unchanged.
REQ-017 out_valid SHALL equal (count>0); the outputs SHALL be driven from slot rd_ptr at index out_idx, in the order in0, in1, in2, in3 (idx 0..3).
REQ-018 Latency: a frame accepted at edge N into an empty buffer SHALL present idx 0 with out_valid=1 in the cycle after edge N.
REQ-019 A transfer SHALL occur when out_valid && out_ready; out_idx SHALL increment on each transfer, wrapping from 3 to 0.
REQ-020 On a transfer with out_last=1, rd_ptr SHALL toggle and count SHALL decrement.
REQ-021 Simultaneous accept and last-transfer in one cycle SHALL leave count unchanged, with both pointers toggled.
REQ-022 While out_valid=1 && out_ready=0, out_r, out_i, out_idx and out_last SHALL hold stable.
REQ-023 With out_ready held at 1, sustained throughput SHALL be 1 sample per cycle, i.e. 1 frame per 4 cycles, with no bubble between back-to-back frames.
REQ-024 While out_valid=0, out_r and out_i SHALL be 0.

Reset
REQ-025 While resetn=0 (asserted asynchronously), count, wr_ptr, rd_ptr, out_idx and overflow SHALL be 0, and out_valid, out_last, out_r and out_i SHALL be 0.
REQ-026 in_ready SHALL be 1 during reset and after reset; any frame or sample in flight when reset asserts SHALL be discarded, with no partial frame emitted after release.
REQ-027 Buffer storage registers SHALL NOT require reset.

Structure
REQ-028 The shared FFT package SHALL hold WIDTH, a FRAME_LEN=4 constant and a complex-sample struct (re, im) typedef.
REQ-029 The block SHALL be a single module with no sub-modules; the ping-pong storage SHALL be an array of 2 frame registers inside it.

Verification
REQ-030 Scenario: reset release, one frame with in0..in3 = (1,-1),(2,-2),(3,-3),(4,-4), out_ready=1 -> 4 consecutive samples in that order, out_idx 0..3, out_last on the 4th, then out_valid=0.
REQ-031 Scenario: 3 frames back-to-back every 4 cycles with out_ready=1 -> 12 contiguous samples, in_ready never 0, overflow=0.
REQ-032 Scenario: out_ready=0, 3 frames offered -> first 2 accepted, in_ready=0 after the 2nd, 3rd dropped, overflow=1; then out_ready=1 -> exactly 8 samples of frames 1 and 2.
REQ-033 Scenario: out_ready toggling 1,0,1,0 -> each sample held stable while stalled, no sample duplicated or lost.
REQ-034 Scenario: resetn pulsed low mid-frame at idx 2 -> out_valid=0 immediately, overflow cleared, next frame starts at idx 0.
REQ-035 Scenario: WIDTH=32, random frames driven from butterfly_radix4 done for 512 frames -> serialized stream matches a reference queue exactly.
